// File: rtl/rotary_interface.sv
// rtl/rotary_interface.sv - quadrature decoder with synchroniser, bounce filter and per-detent pulses
module rotary_interface #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] rotary,
    output logic       rotary_left,
    output logic       rotary_right
);

    logic [1:0] r_sync [SYNC_STAGES];
    logic       r_q1;
    logic       r_q2;
    logic       r_q1_d;
    logic       r_left;
    logic       r_right;
    logic [1:0] w_s;
    logic       w_event;

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_event = r_q1 & ~r_q1_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 2'b00;
            end
            r_q1    <= 1'b0;
            r_q2    <= 1'b0;
            r_q1_d  <= 1'b0;
            r_left  <= 1'b0;
            r_right <= 1'b0;
        end else begin
            r_sync[0] <= rotary;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            // q1 only moves on the settled states 00/11, q2 only on the mixed states,
            // so chatter on a single phase can never retrigger q1.
            case (w_s)
                2'b00:   r_q1 <= 1'b0;
                2'b01:   r_q2 <= 1'b0;
                2'b10:   r_q2 <= 1'b1;
                default: r_q1 <= 1'b1;
            endcase
            r_q1_d  <= r_q1;
            r_left  <= w_event & r_q2;
            r_right <= w_event & ~r_q2;
        end
    end

    assign rotary_left  = r_left;
    assign rotary_right = r_right;

endmodule

// File: tb/tb_rotary_interface.sv
// tb/tb_rotary_interface.sv - randomized scoreboard bench for rotary_interface
module tb_rotary_interface;

    localparam int SYNC_STAGES = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rotary = 2'b00;
    logic       rotary_left;
    logic       rotary_right;

    rotary_interface #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clock        (clock),
        .reset        (reset),
        .rotary       (rotary),
        .rotary_left  (rotary_left),
        .rotary_right (rotary_right)
    );

    always #5 clock = ~clock;

    typedef struct {
        int due;
        bit left;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] pipe[$];
    bit         m_level = 1'b0;
    bit         m_b_led = 1'b0;
    int         edge_cnt = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         n_left = 0;
    int         n_right = 0;
    logic [1:0] s;

    // Reference: a detent fires when the delayed input reaches 11 after last settling at 00;
    // its direction is whichever phase most recently led on its own.
    always @(posedge clock) begin
        edge_cnt++;
        if (reset) begin
            pipe.delete();
            for (int i = 0; i < SYNC_STAGES; i++) pipe.push_back(2'b00);
            m_level = 1'b0;
            m_b_led = 1'b0;
            while (sb.size() > 0 && sb[$].due >= edge_cnt) void'(sb.pop_back());
        end else begin
            s = (pipe.size() > 0) ? pipe.pop_front() : 2'b00;
            pipe.push_back(rotary);
            if (s == 2'b11 && !m_level) sb.push_back('{edge_cnt + 1, m_b_led});
            if (s == 2'b00) m_level = 1'b0;
            if (s == 2'b11) m_level = 1'b1;
            if (s == 2'b01) m_b_led = 1'b0;
            if (s == 2'b10) m_b_led = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (edge_cnt > 0) begin
            bit exp_l;
            bit exp_r;
            exp_l = 1'b0;
            exp_r = 1'b0;
            if (sb.size() > 0 && sb[0].due == edge_cnt) begin
                exp_l = sb[0].left;
                exp_r = !sb[0].left;
                void'(sb.pop_front());
            end
            vectors++;
            if ({rotary_left, rotary_right} !== {exp_l, exp_r}) begin
                miscompares++;
                $display("FAIL pulse edge=%0d got left/right=%b%b expected %b%b",
                         edge_cnt, rotary_left, rotary_right, exp_l, exp_r);
            end
            if (rotary_left === 1'b1) n_left++;
            if (rotary_right === 1'b1) n_right++;
        end
    end

    task automatic step(input logic [1:0] r, input logic rs);
        @(posedge clock);
        #2;
        rotary = r;
        reset  = rs;
    endtask

    task automatic hold(input logic [1:0] r, input int n);
        for (int i = 0; i < n; i++) step(r, 1'b0);
    endtask

    task automatic check_cnt(input string name, input int l0, input int r0,
                             input int exp_l, input int exp_r);
        vectors++;
        if ((n_left - l0) != exp_l || (n_right - r0) != exp_r) begin
            miscompares++;
            $display("FAIL %s got left=%0d right=%0d expected left=%0d right=%0d",
                     name, n_left - l0, n_right - r0, exp_l, exp_r);
        end
    endtask

    initial begin
        int l0;
        int r0;
        step(2'b00, 1'b1);
        step(2'b00, 1'b1);
        l0 = n_left; r0 = n_right;
        hold(2'b00, 8);
        check_cnt("reset_idle", l0, r0, 0, 0);

        l0 = n_left; r0 = n_right;
        hold(2'b10, 1); hold(2'b11, 1); hold(2'b00, 8);
        check_cnt("left_detent", l0, r0, 1, 0);

        l0 = n_left; r0 = n_right;
        hold(2'b01, 5); hold(2'b11, 5); hold(2'b00, 8);
        check_cnt("right_detent", l0, r0, 0, 1);

        l0 = n_left; r0 = n_right;
        for (int i = 0; i < 5; i++) begin step(2'b10, 1'b0); step(2'b00, 1'b0); end
        step(2'b10, 1'b0);
        for (int i = 0; i < 3; i++) begin step(2'b11, 1'b0); step(2'b10, 1'b0); end
        hold(2'b11, 2); hold(2'b00, 8);
        check_cnt("bounce", l0, r0, 1, 0);

        l0 = n_left; r0 = n_right;
        hold(2'b01, 10); hold(2'b00, 5); hold(2'b01, 5); hold(2'b10, 10);
        check_cnt("no_detent", l0, r0, 0, 0);
        hold(2'b00, 5);

        l0 = n_left; r0 = n_right;
        hold(2'b01, 3); step(2'b11, 1'b0); step(2'b11, 1'b0);
        step(2'b00, 1'b1);
        hold(2'b00, 8);
        check_cnt("reset_mid_event", l0, r0, 0, 0);
        l0 = n_left; r0 = n_right;
        hold(2'b10, 2); hold(2'b11, 2); hold(2'b00, 8);
        check_cnt("after_reset_detent", l0, r0, 1, 0);

        l0 = n_left; r0 = n_right;
        hold(2'b11, 3);
        for (int i = 0; i < 3; i++) step(2'b11, 1'b1);
        hold(2'b11, 10);
        check_cnt("held_11_reset", l0, r0, 0, 1);
        hold(2'b00, 5);

        for (int k = 0; k < 300; k++) begin
            int mode;
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                for (int j = 0; j < 6; j++) hold(2'($urandom_range(0, 3)), $urandom_range(1, 4));
            end else if (mode == 1) begin
                if ($urandom_range(0, 1) == 1) begin
                    hold(2'b01, $urandom_range(1, 3)); hold(2'b11, $urandom_range(1, 3));
                    hold(2'b10, $urandom_range(1, 3)); hold(2'b00, $urandom_range(1, 3));
                end else begin
                    hold(2'b10, $urandom_range(1, 3)); hold(2'b11, $urandom_range(1, 3));
                    hold(2'b01, $urandom_range(1, 3)); hold(2'b00, $urandom_range(1, 3));
                end
            end else if (mode == 2) begin
                for (int j = 0; j < 4; j++) step(2'($urandom_range(0, 3)), 1'b0);
            end else begin
                step(2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
                hold(2'($urandom_range(0, 3)), $urandom_range(1, 3));
            end
        end

        hold(2'b00, 10);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending pulses expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
